// File: rtl/arb_mux_pkg.sv
// Shared definitions for arb_mux: clog2 helper, index-width rule, reset values.
// Optional feature macro: ARB_MUX_RR_EN (round-robin when defined, fixed priority otherwise).
package arb_mux_pkg;

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = (n > 1) ? n - 1 : 0;
    while (v != 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Channel-index width: never narrower than one bit.
  function automatic int unsigned idw_of(input int unsigned nch);
    return (nch < 2) ? 1 : clog2(nch);
  endfunction

  // Output register reset values (data/id are filled with this bit).
  localparam logic OUT_VALID_RST = 1'b0;
  localparam logic OUT_FILL_RST  = 1'b0;

endpackage

// File: rtl/arb_mux_if.sv
// Request/response bus for arb_mux: NCH valid/ready inputs and one registered output.
interface arb_mux_if
  import arb_mux_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NCH   = 2
);
  localparam int unsigned IDW = idw_of(NCH);

  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic [NCH*WIDTH-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_data;
  logic [IDW-1:0]       out_id;

  // Requesters plus downstream consumer.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_id
  );

  // The multiplexer.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_id
  );
endinterface

// File: rtl/arb_mux_rr_arbiter.sv
// Combinational arbiter: round-robin search from ptr with wrap (ARB_MUX_RR_EN),
// otherwise a lowest-index priority encoder.
module arb_mux_rr_arbiter
  import arb_mux_pkg::*;
#(
  parameter int unsigned NCH = 2
) (
  input  logic [NCH-1:0]         req,
`ifdef ARB_MUX_RR_EN
  input  logic [idw_of(NCH)-1:0] ptr,
`endif
  output logic [NCH-1:0]         grant,
  output logic [idw_of(NCH)-1:0] idx
);
  localparam int unsigned IDW = idw_of(NCH);

`ifdef ARB_MUX_RR_EN
  logic [NCH-1:0] req_hi;

  // Requests at or above ptr get first look; the rest cover the wrap.
  always_comb begin
    req_hi = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      req_hi[i] = req[i] && (IDW'(i) >= ptr);
    end
  end

  // First set bit of req_hi, else first set bit of req.
  always_comb begin
    logic found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (!found && req_hi[i]) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        idx      = IDW'(i);
      end
    end
    for (int unsigned i = 0; i < NCH; i++) begin
      if (!found && req[i]) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        idx      = IDW'(i);
      end
    end
  end
`else
  // Lowest-index request wins.
  always_comb begin
    logic found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (!found && req[i]) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        idx      = IDW'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/arb_mux.sv
// N-channel registered request multiplexer with valid/ready on every channel.
// ARB_MUX_RR_EN defined: round-robin with rotating pointer; undefined: fixed priority.
module arb_mux
  import arb_mux_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NCH   = 2
) (
  input logic      clk,
  input logic      resetn,
  arb_mux_if.slave bus
);
  localparam int unsigned IDW = idw_of(NCH);

  logic             load_c;
  logic             xfer_c;
  logic [NCH-1:0]   grant_c;
  logic [IDW-1:0]   gidx_c;
  logic [WIDTH-1:0] sel_data_c;

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [IDW-1:0]   out_id_q;

`ifdef ARB_MUX_RR_EN
  logic [IDW-1:0]   ptr_q;
`endif

  arb_mux_rr_arbiter #(.NCH(NCH)) u_arb (
    .req   (bus.in_valid),
`ifdef ARB_MUX_RR_EN
    .ptr   (ptr_q),
`endif
    .grant (grant_c),
    .idx   (gidx_c)
  );

  // Output register may be refilled when empty or being drained this edge;
  // reset gating keeps in_ready low while resetn is asserted.
  assign load_c       = !out_valid_q || bus.out_ready;
  assign xfer_c       = resetn && load_c && (|bus.in_valid);
  assign bus.in_ready = xfer_c ? grant_c : '0;

  // One-hot data select of the granted channel.
  always_comb begin
    sel_data_c = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (grant_c[i]) sel_data_c = bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  // One-entry output register: load on transfer, clear on drain, hold on stall.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid_q <= OUT_VALID_RST;
      out_data_q  <= {WIDTH{OUT_FILL_RST}};
      out_id_q    <= {IDW{OUT_FILL_RST}};
    end else if (load_c) begin
      if (xfer_c) begin
        out_valid_q <= 1'b1;
        out_data_q  <= sel_data_c;
        out_id_q    <= gidx_c;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

`ifdef ARB_MUX_RR_EN
  // Round-robin pointer: moves past the winner on transfers only.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr_q <= '0;
    end else if (xfer_c) begin
      ptr_q <= (gidx_c == IDW'(NCH - 1)) ? '0 : IDW'(gidx_c + IDW'(1));
    end
  end
`endif

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_id    = out_id_q;

endmodule

// File: doc/arb_mux.md
# arb_mux

Parametrised N-channel registered request multiplexer with valid/ready handshake on every channel. It selects one of NCH requesters by round-robin, or by fixed priority when built without round-robin, and holds the selection in a one-entry output register. It is the successor to the plain 2:1 select mux. Its first use is merging the instruction-fetch and data-memory request streams in front of the AXI bridge; the generic width and channel count allow reuse for uncached/cached and write-buffer paths.

## Interface
- WIDTH, 32, payload bits per channel
- NCH, 2, number of input channels, ≥2, need not be a power of two
- IDW, $clog2(NCH), width of the channel-index output; derived, not overridden
- clk  input  1  single clock, rising edge
- resetn  input  1  reset; asynchronous assert, active-low
- in_valid  input  NCH  request valid, bit i = channel i
- in_ready  output  NCH  request accepted, bit i = channel i; one-hot or zero
- in_data  input  NCH*WIDTH  payloads, channel i at bits [i*WIDTH +: WIDTH]
- out_valid  output  1  output register holds a request
- out_ready  input  1  downstream accepts the request
- out_data  output  WIDTH  registered payload of the granted channel
- out_id  output  IDW  registered index of the granted channel

## Operation
- load = !out_valid || out_ready. The output register may be (re)filled this cycle.
- The arbiter picks the winner g among the set bits of in_valid.
  - Round-robin: search starts at ptr and proceeds ptr, ptr+1, …, wrapping NCH-1 → 0.
- in_ready[i] = load && (any in_valid) && (i == g). At most one bit is set.
- Transfer on channel i: in_valid[i] && in_ready[i]. On that edge:
  - out_data ← in_data[g]
  - out_id ← g
  - out_valid ← 1
  - ptr ← (g == NCH-1) ? 0 : g+1
- Output handshake:
  - If out_valid && out_ready and no input is valid, out_valid ← 0.
  - If out_valid && !out_ready, out_data, out_id and out_valid hold exactly (AXI stability rule).
- Simultaneous drain and refill (out_valid && out_ready && some in_valid) gives back-to-back issue with no bubble.
- in_ready is combinational from out_ready, out_valid, in_valid and ptr.
  - Requesters must not make in_valid depend on in_ready.
  - in_ready[i] may depend on other channels' in_valid.
- A requester that loses arbitration keeps in_valid and its data stable until it is granted. Starvation bound in RR mode: NCH-1 grants.
- ptr is held in a register only. It advances only on a transfer, never on stall or idle cycles.

## Timing
- Reset values (asynchronous, while resetn=0): out_valid=0, out_data=0, out_id=0, ptr=0 (channel 0 has highest priority). in_ready is 0 during reset.
- Latency: input transfer at edge k puts out_valid=1 with the payload visible after edge k.
- Throughput: one request per cycle while out_ready is held high.
- Reset mid-operation: the held request is discarded, no output is issued, and ptr returns to 0.
- Release of reset: the first grant is on the first edge after resetn rises with valid inputs.
- Non-power-of-two NCH: ptr and g never exceed NCH-1. The out_id values NCH..2^IDW-1 never appear.

## Configuration
- ARB_MUX_RR_EN defined: round-robin arbitration with rotating ptr as above.
- ARB_MUX_RR_EN undefined: fixed priority, lowest-index valid channel wins.
  - ptr register is removed; higher channels may starve.
  - All other handshake and timing behaviour is identical.

## Structure
- Shared package/header: the clog2 helper function, the IDW derivation rule, and reset-value constants for the output register.
- Natural sub-module: rr_arbiter.
  - Inputs: req[NCH], ptr.
  - Outputs: one-hot grant and binary index.
  - Purely combinational search with wrap.
  - Under ARB_MUX_RR_EN undefined it degenerates to a priority encoder.
- arb_mux owns ptr, the load condition, the output register and the data select.

## Test plan
- Reset: resetn=0 with random inputs → out_valid=0, out_data=0, out_id=0, in_ready=0; after release, only channel 0 valid with data 0x1111_1111 → in_ready=01, next cycle out_valid=1, out_data=0x1111_1111, out_id=0.
- Contention (NCH=2, RR): both valid continuously, out_ready=1 → grants alternate 0,1,0,1, out_id follows one cycle later; fixed-priority build → always 0.
- Backpressure: out_valid=1, out_ready=0 for 5 cycles with new inputs valid → in_ready=0, out_data/out_id unchanged; out_ready=1 → new request loaded the same edge, no bubble.
- Wrap/non-power-of-two (NCH=3, IDW=2): all valid, out_ready=1 → out_id sequence 0,1,2,0,1; never 3.
- Idle drain: single request accepted, then no inputs and out_ready=1 → out_valid drops after one cycle, ptr unchanged across 10 idle cycles.
- Reset mid-op: out_valid=1, out_ready=0, assert resetn=0 between edges → out_valid=0 immediately; the next grant starts from channel 0.
